cache_fill_fsm: RTL
===================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter MEM_LATENCY, default 4: cycles from a main-memory read request to its data_valid; used only by the verification model.
REQ-002 Parameter BLOCK_WORDS, default 8: 16-bit words per cache block (16 bytes).
REQ-003 The block SHALL have one clock and synchronous active-high reset, with ports `clk` and `rst`.
REQ-004 Ports SHALL be:
- `clk`  in  1  clock
- `rst`  in  1  sync reset
- `i_miss`  in  1  I-cache miss
- `i_miss_addr`  in  16  I miss address
- `d_miss`  in  1  D-cache miss
- `d_miss_addr`  in  16  D miss address
- `mem_enable`  out  1  memory read request
- `mem_addr`  out  16  request address
- `mem_data_valid`  in  1  returned word valid
- `mem_data_in`  in  16  returned word
- `fill_data`  out  16  word to cache data array
- `word_num`  out  3  word index in block
- `i_write_data`  out  1  I data-array write strobe
- `i_write_tag`  out  1  I tag-array write strobe
- `d_write_data`  out  1  D data-array write strobe
- `d_write_tag`  out  1  D tag-array write strobe
- `i_stall`  out  1  I-side stall
- `d_stall`  out  1  D-side stall
- `busy`  out  1  fill in progress

Function
REQ-005 The FSM SHALL have states IDLE, FILL, TAG.
REQ-006 In IDLE, a sampled miss SHALL be granted as follows:
- d_miss wins over i_miss.
- Latch owner and base = miss_addr & 16'hFFF0.
- Go to FILL next edge.
REQ-007 In FILL, requests SHALL be issued on the first 8 cycles:
- mem_enable=1.
- mem_addr = base + 2*issue_cnt, with issue_cnt 0..7.
- mem_enable=0 afterwards.
REQ-008 Each mem_data_valid in FILL SHALL be forwarded combinationally in the same cycle:
- fill_data = mem_data_in.
- word_num = recv_cnt.
- Owner's write_data strobe = 1.
- recv_cnt increments.
REQ-009 On the valid with recv_cnt==7, the next state SHALL be TAG.
REQ-010 TAG SHALL last exactly one cycle:
- Owner's write_tag = 1.
- Then IDLE, with no pipelined grant; one bubble cycle minimum between fills.
REQ-011 The stall outputs SHALL be:
- d_stall = d_miss | (busy & owner==D).
- i_stall = i_miss | (busy & owner==I).
REQ-012 busy SHALL be 1 in FILL and TAG, else 0.
REQ-013 Boundary conditions:
- mem_data_valid outside FILL SHALL be ignored (no strobes).
- Miss deassertion mid-fill SHALL NOT abort; the block completes.
- Simultaneous misses: D is filled first; I is granted on the first IDLE cycle after D's TAG.
- Address arithmetic SHALL be 16-bit with wrap: base 16'hFFF0 issues 16'hFFF0..16'hFFFE.
- Non-owner strobes SHALL always be 0.
REQ-014 Counters SHALL be 3-bit, and both SHALL reset to 0 on entry to FILL.

Reset
REQ-015 When rst=1 at a clk edge, the block SHALL apply the following regardless of state (including mid-fill):
- State becomes IDLE; issue_cnt, recv_cnt and owner clear.
- All strobes, mem_enable, busy = 0.
- mem_addr, fill_data = 16'h0000; word_num = 0.
- Stalls reflect only the miss inputs.
REQ-016 In-flight memory returns arriving after reset SHALL be ignored per REQ-013.

Structure
REQ-017 Package cache_pkg SHALL hold:
- State enum IDLE/FILL/TAG.
- BLOCK_WORDS.
- BLOCK_MASK 16'hFFF0.
- Owner encoding OWN_I/OWN_D.
REQ-018 Arbitration SHALL live in one sub-module, miss_arbiter: D-priority grant, registered owner.
- The counters and FSM stay in cache_fill_fsm.

Verification (memory model latency 4, 1 request/cycle)
REQ-019 d_miss=1 at 16'h1236, with a sampling edge of cycle 0:
- mem_addr 16'h1230..16'h123E on cycles 1-8.
- d_write_data on cycles 5-12 with word_num 0..7.
- d_write_tag on cycle 13; busy falls on cycle 14.
REQ-020 i_miss and d_miss assert the same cycle (addresses 16'h0040 and 16'h2000):
- The D fill completes with no I strobe.
- I requests start at 16'h0040 after one IDLE cycle.
- i_stall stays 1 throughout.
REQ-021 i_miss at 16'hFFFA:
- Requests 16'hFFF0..16'hFFFE.
- No access to 16'h0000.
REQ-022 rst pulsed on cycle 6 of a D fill:
- All outputs 0 on the next cycle.
- Late valids on cycles 7-12 produce no strobes.
- A new miss afterwards fills correctly from word 0.
REQ-023 d_miss dropped on cycle 3:
- All 8 d_write_data strobes and d_write_tag are still produced.
REQ-024 mem_data_valid pulsed in IDLE with no miss:
- No strobes.
- busy stays 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache block-fill controller.
// Owner encoding is one bit: the side whose block is being filled.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, FILL, TAG} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  localparam int          BLOCK_WORDS = 8;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
endpackage

// File: rtl/miss_arbiter.sv
// D-priority miss arbiter: grants only while the fill engine is idle and
// latches the winning side plus its block-aligned base address.
module miss_arbiter
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        grant_en,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  output logic        grant,
  output owner_e      owner,
  output logic [15:0] base
);
  owner_e      owner_q, owner_d;
  logic [15:0] base_q, base_d;

  always_comb begin
    grant   = grant_en & (i_miss | d_miss);
    owner_d = owner_q;
    base_d  = base_q;
    if (grant) begin
      if (d_miss) begin
        owner_d = OWN_D;
        base_d  = d_miss_addr & BLOCK_MASK;
      end else begin
        owner_d = OWN_I;
        base_d  = i_miss_addr & BLOCK_MASK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_I;
      base_q  <= 16'h0000;
    end else begin
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  assign owner = owner_q;
  assign base  = base_q;
endmodule

// File: rtl/cache_fill_fsm.sv
// Block-fill controller: issues one read per cycle for a whole block, forwards
// each returned word to the owning cache in the same cycle, then writes the tag.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  output logic        mem_enable,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_in,
  output logic [15:0] fill_data,
  output logic [2:0]  word_num,
  output logic        i_write_data,
  output logic        i_write_tag,
  output logic        d_write_data,
  output logic        d_write_tag,
  output logic        i_stall,
  output logic        d_stall,
  output logic        busy
);
  localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

  // Memory latency only shapes the external memory; the FSM is latency-agnostic.
  logic [31:0] unused_mem_latency;
  assign unused_mem_latency = 32'(MEM_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic        issue_done_q, issue_done_d;
  logic        busy_q, busy_d;
  logic        grant;
  owner_e      owner;
  logic [15:0] base;
  logic        fill_vld;

  miss_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .grant_en    (state_q == IDLE),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .grant       (grant),
    .owner       (owner),
    .base        (base)
  );

  always_comb begin
    mem_enable   = (state_q == FILL) && !issue_done_q;
    mem_addr     = mem_enable ? (base + {12'd0, issue_cnt_q, 1'b0}) : 16'h0000;
    // Returns outside FILL belong to an aborted or foreign request and are dropped.
    fill_vld     = (state_q == FILL) && mem_data_valid;
    fill_data    = fill_vld ? mem_data_in : 16'h0000;
    word_num     = fill_vld ? recv_cnt_q : 3'd0;
    d_write_data = fill_vld && (owner == OWN_D);
    i_write_data = fill_vld && (owner == OWN_I);
    d_write_tag  = (state_q == TAG) && (owner == OWN_D);
    i_write_tag  = (state_q == TAG) && (owner == OWN_I);

    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    issue_done_d = issue_done_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = FILL;
          issue_cnt_d  = 3'd0;
          recv_cnt_d   = 3'd0;
          issue_done_d = 1'b0;
        end
      end
      FILL: begin
        if (mem_enable) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_q == LAST_WORD) issue_done_d = 1'b1;
        end
        if (fill_vld) begin
          recv_cnt_d = recv_cnt_q + 3'd1;
          if (recv_cnt_q == LAST_WORD) state_d = TAG;
        end
      end
      TAG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      issue_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      issue_done_q <= issue_done_d;
      busy_q       <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign d_stall = d_miss | (busy_q && (owner == OWN_D));
  assign i_stall = i_miss | (busy_q && (owner == OWN_I));
endmodule
